// File: rtl/cache_arbiter.sv
// Shares one AXI4-Lite cache port between instruction fetch (read-only) and the memory stage.
// One transaction in flight, round-robin read arbitration, response watchdog with SLVERR fallback.
module cache_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256,
  parameter int CNT_WIDTH = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  // fetch requester
  input  logic              instr_arvalid,
  output logic              instr_arready,
  input  logic [ADDR_W-1:0] instr_araddr,
  input  logic [2:0]        instr_arprot,
  output logic              instr_rvalid,
  input  logic              instr_rready,
  output logic [DATA_W-1:0] instr_rdata,
  output logic [1:0]        instr_rresp,
  output logic              instr_awready,
  output logic              instr_wready,
  output logic              instr_bvalid,
  // memory-stage requester
  input  logic              data_arvalid,
  output logic              data_arready,
  input  logic [ADDR_W-1:0] data_araddr,
  input  logic [2:0]        data_arprot,
  output logic              data_rvalid,
  input  logic              data_rready,
  output logic [DATA_W-1:0] data_rdata,
  output logic [1:0]        data_rresp,
  input  logic              data_awvalid,
  output logic              data_awready,
  input  logic [ADDR_W-1:0] data_awaddr,
  input  logic [2:0]        data_awprot,
  input  logic              data_wvalid,
  output logic              data_wready,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic              data_bvalid,
  input  logic              data_bready,
  output logic [1:0]        data_bresp,
  // shared cache port
  output logic              cache_arvalid,
  input  logic              cache_arready,
  output logic [ADDR_W-1:0] cache_araddr,
  output logic [2:0]        cache_arprot,
  input  logic              cache_rvalid,
  output logic              cache_rready,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic [1:0]        cache_rresp,
  output logic              cache_awvalid,
  input  logic              cache_awready,
  output logic [ADDR_W-1:0] cache_awaddr,
  output logic [2:0]        cache_awprot,
  output logic              cache_wvalid,
  input  logic              cache_wready,
  output logic [DATA_W-1:0] cache_wdata,
  output logic [DATA_W/8-1:0] cache_wstrb,
  input  logic              cache_bvalid,
  output logic              cache_bready,
  input  logic [1:0]        cache_bresp
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DRAIN = 2'd3} state_t;

  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [1:0] SLVERR = 2'b10;

  state_t               state, state_nxt;
  logic                 owner, owner_nxt;
  logic                 last, last_nxt;
  logic                 ar_done, ar_done_nxt;
  logic                 aw_done, aw_done_nxt;
  logic                 w_done, w_done_nxt;
  logic                 err, err_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

  logic                 own_arvalid, own_rready;
  logic                 ar_fire, aw_fire, w_fire;
  logic                 r_valid;
  logic [DATA_W-1:0]    r_data;
  logic [1:0]           r_resp;

  assign own_arvalid   = owner ? data_arvalid : instr_arvalid;
  assign own_rready    = owner ? data_rready  : instr_rready;
  assign cache_araddr  = owner ? data_araddr  : instr_araddr;
  assign cache_arprot  = owner ? data_arprot  : instr_arprot;
  assign cache_awaddr  = data_awaddr;
  assign cache_awprot  = data_awprot;
  assign cache_wdata   = data_wdata;
  assign cache_wstrb   = data_wstrb;
  assign instr_awready = 1'b0;
  assign instr_wready  = 1'b0;
  assign instr_bvalid  = 1'b0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      ar_done <= ar_done_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      err     <= err_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    ar_done_nxt   = ar_done;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    err_nxt       = err;
    cnt_nxt       = cnt;
    cache_arvalid = 1'b0;
    cache_rready  = 1'b0;
    cache_awvalid = 1'b0;
    cache_wvalid  = 1'b0;
    cache_bready  = 1'b0;
    instr_arready = 1'b0;
    data_arready  = 1'b0;
    data_awready  = 1'b0;
    data_wready   = 1'b0;
    data_bvalid   = 1'b0;
    data_bresp    = cache_bresp;
    r_valid       = 1'b0;
    r_data        = cache_rdata;
    r_resp        = cache_rresp;
    ar_fire       = 1'b0;
    aw_fire       = 1'b0;
    w_fire        = 1'b0;

    unique case (state)
      IDLE: begin
        // reads beat writes; contended reads go to the port that did not win last
        if (instr_arvalid && data_arvalid) begin
          state_nxt = READ;
          owner_nxt = ~last;
        end else if (instr_arvalid) begin
          state_nxt = READ;
          owner_nxt = 1'b0;
        end else if (data_arvalid) begin
          state_nxt = READ;
          owner_nxt = 1'b1;
        end else if (data_awvalid && data_wvalid) begin
          state_nxt = WRITE;
          owner_nxt = 1'b1;
        end
      end

      READ: begin
        cache_arvalid = own_arvalid & ~ar_done;
        instr_arready = ~owner & cache_arready & ~ar_done;
        data_arready  = owner & cache_arready & ~ar_done;
        ar_fire       = cache_arvalid & cache_arready;
        if (ar_fire) begin
          ar_done_nxt = 1'b1;
          cnt_nxt     = '0;
        end
        if (err) begin
          r_valid = 1'b1;
          r_data  = '0;
          r_resp  = SLVERR;
          if (own_rready) begin
            state_nxt   = DRAIN;
            last_nxt    = owner;
            ar_done_nxt = 1'b0;
            err_nxt     = 1'b0;
            cnt_nxt     = '0;
          end
        end else if (ar_done) begin
          r_valid      = cache_rvalid;
          cache_rready = own_rready;
          if (cache_rvalid && own_rready) begin
            state_nxt   = IDLE;
            last_nxt    = owner;
            ar_done_nxt = 1'b0;
            cnt_nxt     = '0;
          end else if (WD_EN) begin
            if (cnt == CNT_LAST) err_nxt = 1'b1;
            else                 cnt_nxt = cnt + 1'b1;
          end
        end
      end

      WRITE: begin
        cache_awvalid = data_awvalid & ~aw_done;
        data_awready  = cache_awready & ~aw_done;
        cache_wvalid  = data_wvalid & ~w_done;
        data_wready   = cache_wready & ~w_done;
        aw_fire       = cache_awvalid & cache_awready;
        w_fire        = cache_wvalid & cache_wready;
        if (aw_fire) aw_done_nxt = 1'b1;
        if (w_fire)  w_done_nxt  = 1'b1;
        if (!(aw_done && w_done) && (aw_done || aw_fire) && (w_done || w_fire))
          cnt_nxt = '0;
        if (err) begin
          data_bvalid = 1'b1;
          data_bresp  = SLVERR;
          if (data_bready) begin
            state_nxt   = DRAIN;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            err_nxt     = 1'b0;
            cnt_nxt     = '0;
          end
        end else if (aw_done && w_done) begin
          data_bvalid  = cache_bvalid;
          cache_bready = data_bready;
          if (cache_bvalid && data_bready) begin
            state_nxt   = IDLE;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            cnt_nxt     = '0;
          end else if (WD_EN) begin
            if (cnt == CNT_LAST) err_nxt = 1'b1;
            else                 cnt_nxt = cnt + 1'b1;
          end
        end
      end

      DRAIN: begin
        // swallow the late response of the timed-out transaction
        cache_rready = 1'b1;
        cache_bready = 1'b1;
        if (cache_rvalid || cache_bvalid) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    instr_rvalid = r_valid & ~owner;
    data_rvalid  = r_valid & owner;
    instr_rdata  = r_data;
    data_rdata   = r_data;
    instr_rresp  = r_resp;
    data_rresp   = r_resp;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reads, round-robin, split AW/W write, watchdog, reset mid-write.
module tb_cache_arbiter;

  logic        aclk, aresetn;
  logic        instr_arvalid, instr_arready, instr_rvalid, instr_rready;
  logic [31:0] instr_araddr, instr_rdata;
  logic [2:0]  instr_arprot;
  logic [1:0]  instr_rresp;
  logic        instr_awready, instr_wready, instr_bvalid;
  logic        data_arvalid, data_arready, data_rvalid, data_rready;
  logic [31:0] data_araddr, data_rdata, data_awaddr, data_wdata;
  logic [2:0]  data_arprot, data_awprot;
  logic [1:0]  data_rresp, data_bresp;
  logic        data_awvalid, data_awready, data_wvalid, data_wready, data_bvalid, data_bready;
  logic [3:0]  data_wstrb;
  logic        cache_arvalid, cache_arready, cache_rvalid, cache_rready;
  logic [31:0] cache_araddr, cache_rdata, cache_awaddr, cache_wdata;
  logic [2:0]  cache_arprot, cache_awprot;
  logic [1:0]  cache_rresp, cache_bresp;
  logic        cache_awvalid, cache_awready, cache_wvalid, cache_wready, cache_bvalid, cache_bready;
  logic [3:0]  cache_wstrb;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .instr_arvalid(instr_arvalid), .instr_arready(instr_arready), .instr_araddr(instr_araddr),
    .instr_arprot(instr_arprot), .instr_rvalid(instr_rvalid), .instr_rready(instr_rready),
    .instr_rdata(instr_rdata), .instr_rresp(instr_rresp), .instr_awready(instr_awready),
    .instr_wready(instr_wready), .instr_bvalid(instr_bvalid),
    .data_arvalid(data_arvalid), .data_arready(data_arready), .data_araddr(data_araddr),
    .data_arprot(data_arprot), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .data_rdata(data_rdata), .data_rresp(data_rresp), .data_awvalid(data_awvalid),
    .data_awready(data_awready), .data_awaddr(data_awaddr), .data_awprot(data_awprot),
    .data_wvalid(data_wvalid), .data_wready(data_wready), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_bvalid(data_bvalid), .data_bready(data_bready),
    .data_bresp(data_bresp),
    .cache_arvalid(cache_arvalid), .cache_arready(cache_arready), .cache_araddr(cache_araddr),
    .cache_arprot(cache_arprot), .cache_rvalid(cache_rvalid), .cache_rready(cache_rready),
    .cache_rdata(cache_rdata), .cache_rresp(cache_rresp), .cache_awvalid(cache_awvalid),
    .cache_awready(cache_awready), .cache_awaddr(cache_awaddr), .cache_awprot(cache_awprot),
    .cache_wvalid(cache_wvalid), .cache_wready(cache_wready), .cache_wdata(cache_wdata),
    .cache_wstrb(cache_wstrb), .cache_bvalid(cache_bvalid), .cache_bready(cache_bready),
    .cache_bresp(cache_bresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    instr_arvalid = 1'b0; instr_araddr = '0; instr_arprot = '0; instr_rready = 1'b1;
    data_arvalid = 1'b0; data_araddr = '0; data_arprot = '0; data_rready = 1'b1;
    data_awvalid = 1'b0; data_awaddr = '0; data_awprot = '0;
    data_wvalid = 1'b0; data_wdata = '0; data_wstrb = '0; data_bready = 1'b1;
    cache_arready = 1'b0; cache_rvalid = 1'b0; cache_rdata = '0; cache_rresp = '0;
    cache_awready = 1'b0; cache_wready = 1'b0; cache_bvalid = 1'b0; cache_bresp = '0;

    // reset state
    tick(); tick();
    aresetn = 1'b1;
    #1;
    chk_w("rst_state", 32'(dut.state), 32'd0);
    chk_b("rst_cache_arvalid", cache_arvalid, 1'b0);
    chk_b("rst_cache_rready", cache_rready, 1'b0);
    chk_b("rst_instr_arready", instr_arready, 1'b0);
    chk_b("rst_data_rvalid", data_rvalid, 1'b0);
    chk_b("rst_instr_awready", instr_awready, 1'b0);
    chk_b("rst_instr_bvalid", instr_bvalid, 1'b0);

    // single instr read, response 3 cycles after AR
    tick();
    instr_arvalid = 1'b1; instr_araddr = 32'h0000_0100; cache_arready = 1'b1;
    #1;
    chk_b("rd1_arvalid_idle", cache_arvalid, 1'b0);
    tick();
    chk_b("rd1_arvalid", cache_arvalid, 1'b1);
    chk_w("rd1_araddr", cache_araddr, 32'h0000_0100);
    chk_b("rd1_arready", instr_arready, 1'b1);
    tick();
    instr_arvalid = 1'b0; cache_arready = 1'b0;
    #1;
    chk_b("rd1_arvalid_done", cache_arvalid, 1'b0);
    tick();
    chk_b("rd1_rvalid_wait", instr_rvalid, 1'b0);
    tick();
    cache_rvalid = 1'b1; cache_rdata = 32'hDEAD_BEEF; cache_rresp = 2'b00;
    #1;
    chk_b("rd1_rvalid", instr_rvalid, 1'b1);
    chk_w("rd1_rdata", instr_rdata, 32'hDEAD_BEEF);
    chk_w("rd1_rresp", 32'(instr_rresp), 32'd0);
    chk_b("rd1_data_rvalid", data_rvalid, 1'b0);
    chk_b("rd1_cache_rready", cache_rready, 1'b1);
    tick();
    cache_rvalid = 1'b0;
    #1;
    chk_w("rd1_state_idle", 32'(dut.state), 32'd0);

    // round-robin: fresh reset so instr wins the first tie
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    instr_arvalid = 1'b1; instr_araddr = 32'h0000_1000;
    data_arvalid = 1'b1; data_araddr = 32'h0000_2000;
    cache_arready = 1'b1; cache_rvalid = 1'b1; cache_rdata = 32'h0000_00AA;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk_b("rr_idle_arvalid", cache_arvalid, 1'b0);
      tick();
      chk_b("rr_arvalid", cache_arvalid, 1'b1);
      chk_w("rr_araddr", cache_araddr, (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      tick();
      chk_b("rr_instr_rvalid", instr_rvalid, (i % 2 == 0));
      chk_b("rr_data_rvalid", data_rvalid, (i % 2 == 1));
      tick();
    end
    instr_arvalid = 1'b0; data_arvalid = 1'b0; cache_arready = 1'b0; cache_rvalid = 1'b0;
    tick();

    // data write, W accepted two cycles before AW
    data_awvalid = 1'b1; data_awaddr = 32'h0000_0010;
    data_wvalid = 1'b1; data_wdata = 32'h0000_AB00; data_wstrb = 4'b0010;
    cache_wready = 1'b1;
    #1;
    chk_b("wr_idle_awvalid", cache_awvalid, 1'b0);
    tick();
    chk_b("wr_wvalid", cache_wvalid, 1'b1);
    chk_w("wr_wdata", cache_wdata, 32'h0000_AB00);
    chk_w("wr_wstrb", 32'(cache_wstrb), 32'h2);
    chk_b("wr_wready", data_wready, 1'b1);
    chk_b("wr_awready_stall", data_awready, 1'b0);
    tick();
    data_wvalid = 1'b0; cache_wready = 1'b0;
    #1;
    chk_b("wr_wvalid_done", cache_wvalid, 1'b0);
    chk_b("wr_awvalid_hold", cache_awvalid, 1'b1);
    tick();
    cache_awready = 1'b1;
    #1;
    chk_b("wr_awready", data_awready, 1'b1);
    chk_w("wr_awaddr", cache_awaddr, 32'h0000_0010);
    tick();
    data_awvalid = 1'b0; cache_awready = 1'b0;
    #1;
    chk_b("wr_awvalid_done", cache_awvalid, 1'b0);
    chk_b("wr_bvalid_wait", data_bvalid, 1'b0);
    cache_bvalid = 1'b1; cache_bresp = 2'b00;
    #1;
    chk_b("wr_bvalid", data_bvalid, 1'b1);
    chk_w("wr_bresp", 32'(data_bresp), 32'd0);
    chk_b("wr_cache_bready", cache_bready, 1'b1);
    tick();
    cache_bvalid = 1'b0;
    #1;
    chk_w("wr_state_idle", 32'(dut.state), 32'd0);

    // watchdog expiry with a late response drained
    tick();
    instr_arvalid = 1'b1; instr_araddr = 32'h0000_0200; cache_arready = 1'b1; instr_rready = 1'b0;
    #1;
    tick();
    chk_b("to_arvalid", cache_arvalid, 1'b1);
    tick();
    instr_arvalid = 1'b0; cache_arready = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk_b("to_rvalid_wait", instr_rvalid, 1'b0);
      tick();
    end
    chk_b("to_rvalid", instr_rvalid, 1'b1);
    chk_w("to_rresp", 32'(instr_rresp), 32'h2);
    chk_w("to_rdata", instr_rdata, 32'h0);
    chk_b("to_cache_rready", cache_rready, 1'b0);
    tick();
    chk_b("to_rvalid_hold", instr_rvalid, 1'b1);
    chk_w("to_rresp_hold", 32'(instr_rresp), 32'h2);
    instr_rready = 1'b1;
    tick();
    chk_w("to_state_drain", 32'(dut.state), 32'd3);
    chk_b("to_drain_rvalid", instr_rvalid, 1'b0);
    tick(); tick(); tick();
    cache_rvalid = 1'b1; cache_rdata = 32'h1234_5678; cache_rresp = 2'b00;
    #1;
    chk_b("to_late_not_fwd", instr_rvalid, 1'b0);
    chk_b("to_drain_rready", cache_rready, 1'b1);
    tick();
    cache_rvalid = 1'b0;
    #1;
    chk_w("to_state_idle", 32'(dut.state), 32'd0);

    // response arrives on the last watchdog cycle and wins
    tick();
    instr_arvalid = 1'b1; instr_araddr = 32'h0000_0300; cache_arready = 1'b1;
    #1;
    tick();
    chk_b("race_arvalid", cache_arvalid, 1'b1);
    tick();
    instr_arvalid = 1'b0; cache_arready = 1'b0;
    #1;
    repeat (7) tick();
    cache_rvalid = 1'b1; cache_rdata = 32'hCAFE_0001; cache_rresp = 2'b00;
    #1;
    chk_b("race_rvalid", instr_rvalid, 1'b1);
    chk_w("race_rresp", 32'(instr_rresp), 32'd0);
    chk_w("race_rdata", instr_rdata, 32'hCAFE_0001);
    tick();
    cache_rvalid = 1'b0;
    #1;
    chk_w("race_state_idle", 32'(dut.state), 32'd0);
    chk_b("race_no_slverr", instr_rvalid, 1'b0);

    // reset while in WRITE with AW done
    data_awvalid = 1'b1; data_awaddr = 32'h0000_0020;
    data_wvalid = 1'b1; data_wdata = 32'h1111_2222; data_wstrb = 4'hF;
    cache_awready = 1'b1; cache_wready = 1'b0;
    tick();
    tick();
    data_awvalid = 1'b0; cache_awready = 1'b0;
    #1;
    chk_b("rstw_awvalid_done", cache_awvalid, 1'b0);
    chk_b("rstw_wvalid", cache_wvalid, 1'b1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    #1;
    chk_w("rstw_state", 32'(dut.state), 32'd0);
    chk_b("rstw_cache_wvalid", cache_wvalid, 1'b0);
    chk_b("rstw_data_wready", data_wready, 1'b0);
    chk_b("rstw_cache_awvalid", cache_awvalid, 1'b0);
    chk_b("rstw_cache_bready", cache_bready, 1'b0);
    chk_b("rstw_cache_arvalid", cache_arvalid, 1'b0);
    data_wvalid = 1'b0;
    instr_arvalid = 1'b1; instr_araddr = 32'h0000_0400; cache_arready = 1'b1;
    #1;
    chk_b("post_idle_arvalid", cache_arvalid, 1'b0);
    tick();
    chk_b("post_arvalid", cache_arvalid, 1'b1);
    chk_w("post_araddr", cache_araddr, 32'h0000_0400);
    tick();
    instr_arvalid = 1'b0; cache_arready = 1'b0;
    cache_rvalid = 1'b1; cache_rdata = 32'h0000_55AA; cache_rresp = 2'b00;
    #1;
    chk_b("post_rvalid", instr_rvalid, 1'b1);
    chk_w("post_rdata", instr_rdata, 32'h0000_55AA);
    tick();
    cache_rvalid = 1'b0;
    #1;
    chk_w("post_state_idle", 32'(dut.state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares one AXI4-Lite cache port between the fetch stage (`instr`, read-only) and the memory stage (`data`, read/write).
- Only one transaction is in flight at a time.
- Read arbitration between requesters is round-robin.
- A per-transaction response watchdog converts a hung cache into an error response, so the pipeline never deadlocks.

Parameters:
- TIMEOUT, 256: cycles allowed from address acceptance to response. 0 disables the watchdog.
- CNT_WIDTH, 16: watchdog counter width. Must satisfy TIMEOUT < 2**CNT_WIDTH.

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset, synchronous, active-low
- instr  axi.slave  -  fetch requester; only AR/R are used; AW/W are never readied, bvalid tied 0
- data  axi.slave  -  memory-stage requester; AR/R/AW/W/B
- cache  axi.master  -  shared downstream cache port

Behaviour:
- FSM states: IDLE, READ, WRITE, DRAIN. Registers: `state`, `owner` (0=instr, 1=data), `last` (last read grant), `ar_done`, `aw_done`, `w_done`, `cnt`.
- Reset values:
  - state=IDLE, owner=0, last=1 (so instr wins the first tie), all done flags 0, cnt=0.
  - All cache valids and readies 0; all requester readies and valids 0.
- IDLE:
  - Requests are `instr.arvalid`, `data.arvalid`, and write (`data.awvalid & data.wvalid`).
  - Grant priority: data read > data write when both are asserted by `data`.
  - Read contention between instr and data: grant the port != `last`.
  - Write is granted only when no read is pending from the round-robin winner.
  - Grant is registered: the chosen state and owner take effect next cycle.
  - Arbitration latency is 1 cycle; no requester ready is asserted in IDLE.
- READ:
  - `cache.araddr` and `arprot` are muxed from the owner; `cache.arvalid = owner.arvalid & ~ar_done`; `owner.arready = cache.arready & ~ar_done`.
  - On the AR handshake: set `ar_done`, clear `cnt`.
  - `owner.rvalid/rdata/rresp` come from cache; `cache.rready = owner.rready`. The non-owner sees arready=0, rvalid=0.
  - On the R handshake: state becomes IDLE, `last` becomes owner, `ar_done` clears.
- WRITE:
  - AW and W forward independently with their own done flags. The B channel opens only once both `aw_done` and `w_done` are set.
  - `cnt` clears when the second of AW/W completes.
  - On the B handshake: state becomes IDLE. `last` is not changed by writes.
- Watchdog (TIMEOUT > 0):
  - `cnt` increments each cycle while the address phase is complete and the response is pending.
  - When cnt == TIMEOUT-1 and no response handshake occurs that cycle:
    - drive owner rvalid/bvalid=1 with resp=SLVERR (2'b10) and rdata=0, held until the owner's ready;
    - then go to DRAIN.
  - DRAIN: cache rready/bready=1 and the late response is discarded. Leave on the first cache rvalid or bvalid and go to IDLE. No new grant is made while in DRAIN.
  - If TIMEOUT=0, `cnt` is held at 0.
- Address phase is not watched: a stalled arready or awready holds forever.
- Boundaries:
  - Requester withdrawing arvalid before the grant takes effect: READ with owner.arvalid=0 waits; this is a protocol violation by the requester and is not checked.
  - Simultaneous cache response and timeout expiry: the response wins and no SLVERR is generated.
  - Reset mid-transaction: immediately back to IDLE with all outputs at reset values. The downstream cache must be reset concurrently.
  - Back-to-back: throughput is 1 transaction per (1 + address + response) cycles. There is no overlap.

Test Plan:
- Single instr read of 0x0000_0100, cache returns 0xDEAD_BEEF/OKAY after 3 cycles -> `instr.rdata`=0xDEAD_BEEF, `data` never sees rvalid, `cache.arvalid` first rises 1 cycle after `instr.arvalid`.
- Instr and data both hold arvalid continuously for 6 transactions -> grants alternate instr, data, instr, ... and araddr matches the owner each time.
- Data write addr 0x10, wdata 0x0000_AB00, wstrb 4'b0010, cache accepts W 2 cycles before AW -> exactly one AW and one W handshake, then B OKAY returned to `data`, then IDLE.
- TIMEOUT=8, cache accepts AR and never asserts rvalid -> owner gets rresp=2'b10, rdata=0 exactly 8 cycles after the AR handshake. A late cache rvalid 5 cycles later is consumed in DRAIN and not forwarded.
- Cache rvalid arrives on the cycle cnt == TIMEOUT-1 -> OKAY data forwarded, no SLVERR, state IDLE.
- aresetn low for 1 cycle while in WRITE with aw_done=1 -> next cycle all valids/readies are 0 and state is IDLE; a subsequent instr read completes normally.
